tone_key_scheduler: RTL and testbench

Arbitrates the 16 launchpad pad keys onto the single ToneConverter instance. It debounces each key and picks one note. It enforces a minimum note length and a silent gap between notes, then drives the converter's 4-bit tone code and enable. It sits between the pad-scan inputs and the ToneConverter `B_in`/`EN` pins.

---
 rtl/tone_key_scheduler.sv | 174 +++++++++++++++++
 tb/tb_tone_key_scheduler.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/tone_key_scheduler.sv
// Debounces 16 pad keys and arbitrates them onto one ToneConverter,
// enforcing a minimum note length and a silent gap between notes.
module tone_key_scheduler #(
  parameter int DEB_CYCLES = 4,
  parameter int MIN_CYCLES = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] KEY,
  output logic [3:0]  B_out,
  output logic        EN_out,
  output logic        BUSY
);

  localparam logic [15:0] DEB_M1 = 16'(DEB_CYCLES - 1);
  localparam logic [15:0] MIN_C  = 16'(MIN_CYCLES);
  localparam logic [15:0] GAP_C  = 16'(GAP_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    GAP
  } state_t;

  logic [15:0] sync1;
  logic [15:0] sync2;
  logic [15:0] deb;
  logic [15:0] deb_q;
  logic [15:0] deb_cnt [16];

  logic [15:0] press;
  logic [15:0] fall;
  logic [15:0] press_m;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  cur;
  logic [3:0]  cur_nx;
  logic [15:0] play_cnt;
  logic [15:0] play_nx;
  logic [15:0] gap_cnt;
  logic [15:0] gap_nx;

  logic        pend_valid;
  logic        pend_valid_nx;
  logic [3:0]  pend_code;
  logic [3:0]  pend_code_nx;

  logic        hold_valid;
  logic [3:0]  hold_code;
  logic        press_any;
  logic [3:0]  press_code;
  logic        pick_valid;
  logic [3:0]  pick_code;
  logic        take;

  // The debounced level flips once the disagreement count reaches DEB_CYCLES.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < 16; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= KEY;
      sync2 <= sync1;
      deb_q <= deb;
      for (int i = 0; i < 16; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_M1) begin
          deb[i]     <= ~deb[i];
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] != 16'hFFFF) begin
          deb_cnt[i] <= deb_cnt[i] + 16'd1;
        end
      end
    end
  end

  assign press   = deb & ~deb_q;
  assign fall    = deb_q & ~deb;
  assign press_m = press & ~(16'd1 << cur);

  always_comb begin
    hold_code  = '0;
    press_code = '0;
    for (int i = 15; i >= 0; i--) begin
      if (deb[i])     hold_code  = 4'(i);
      if (press_m[i]) press_code = 4'(i);
    end
    hold_valid = |deb;
    press_any  = |press_m;
    pick_valid = pend_valid | hold_valid;
    pick_code  = pend_valid ? pend_code : hold_code;
  end

  always_comb begin
    state_nx = state;
    cur_nx   = cur;
    play_nx  = play_cnt;
    gap_nx   = gap_cnt;
    take     = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nx = PLAY;
          cur_nx   = pick_code;
          play_nx  = 16'd1;
          take     = pend_valid;
        end
      end
      PLAY: begin
        if (play_cnt < MIN_C) play_nx = play_cnt + 16'd1;
        if (play_cnt >= MIN_C && (!deb[cur] || pend_valid)) begin
          state_nx = GAP;
          gap_nx   = 16'd1;
        end
      end
      GAP: begin
        if (gap_cnt != 16'hFFFF) gap_nx = gap_cnt + 16'd1;
        if (gap_cnt == GAP_C) begin
          if (pick_valid) begin
            state_nx = PLAY;
            cur_nx   = pick_code;
            play_nx  = 16'd1;
            take     = pend_valid;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // A fresh press always wins over clearing, so it is never lost.
  always_comb begin
    pend_valid_nx = pend_valid;
    pend_code_nx  = pend_code;
    if (take || (pend_valid && fall[pend_code])) pend_valid_nx = 1'b0;
    if ((state == PLAY || state == GAP) && press_any) begin
      pend_valid_nx = 1'b1;
      pend_code_nx  = press_code;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      cur        <= '0;
      play_cnt   <= '0;
      gap_cnt    <= '0;
      pend_valid <= 1'b0;
      pend_code  <= '0;
      B_out      <= '0;
      EN_out     <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      state      <= state_nx;
      cur        <= cur_nx;
      play_cnt   <= play_nx;
      gap_cnt    <= gap_nx;
      pend_valid <= pend_valid_nx;
      pend_code  <= pend_code_nx;
      B_out      <= cur_nx;
      EN_out     <= (state_nx == PLAY);
      BUSY       <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_tone_key_scheduler.sv
// Directed table-driven bench for tone_key_scheduler with default
// parameters, plus hand sequences for reset hold and async reset.
module tb_tone_key_scheduler;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] KEY;
  logic [3:0]  B_out;
  logic        EN_out;
  logic        BUSY;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] key;
    int          ticks;
    logic [3:0]  b;
    logic        en;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  tone_key_scheduler #(
    .DEB_CYCLES(4),
    .MIN_CYCLES(8),
    .GAP_CYCLES(2)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .KEY(KEY),
    .B_out(B_out),
    .EN_out(EN_out),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic add(input logic [15:0] k, input int t,
                     input logic [3:0] b, input logic en,
                     input logic busy);
    vec_t v;
    v.key   = k;
    v.ticks = t;
    v.b     = b;
    v.en    = en;
    v.busy  = busy;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [3:0] b,
                     input logic en, input logic busy);
    n_vec++;
    if (B_out !== b || EN_out !== en || BUSY !== busy) begin
      n_bad++;
      $display("FAIL %s: got B=%0d EN=%0b BUSY=%0b want B=%0d EN=%0b BUSY=%0b",
               name, B_out, EN_out, BUSY, b, en, busy);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1;
    KEY = 16'h0008;

    // single note on key 3, released after 20 edges
    add(16'h0008,  6, 4'd0, 1'b0, 1'b0);
    add(16'h0008,  1, 4'd3, 1'b1, 1'b1);
    add(16'h0008, 13, 4'd3, 1'b1, 1'b1);
    add(16'h0000,  6, 4'd3, 1'b1, 1'b1);
    add(16'h0000,  1, 4'd3, 1'b0, 1'b1);
    add(16'h0000,  1, 4'd3, 1'b0, 1'b1);
    add(16'h0000,  1, 4'd3, 1'b0, 1'b0);
    add(16'h0000,  5, 4'd3, 1'b0, 1'b0);
    // 3-cycle glitch on key 5
    add(16'h0020,  3, 4'd3, 1'b0, 1'b0);
    add(16'h0000, 10, 4'd3, 1'b0, 1'b0);
    // keys 2 and 5 together; 5 released before its minimum
    add(16'h0024,  6, 4'd3, 1'b0, 1'b0);
    add(16'h0024,  1, 4'd2, 1'b1, 1'b1);
    add(16'h0024, 10, 4'd2, 1'b1, 1'b1);
    add(16'h0020,  6, 4'd2, 1'b1, 1'b1);
    add(16'h0020,  1, 4'd2, 1'b0, 1'b1);
    add(16'h0020,  1, 4'd2, 1'b0, 1'b1);
    add(16'h0020,  1, 4'd5, 1'b1, 1'b1);
    add(16'h0000,  7, 4'd5, 1'b1, 1'b1);
    add(16'h0000,  1, 4'd5, 1'b0, 1'b1);
    add(16'h0000,  1, 4'd5, 1'b0, 1'b1);
    add(16'h0000,  1, 4'd5, 1'b0, 1'b0);
    // key 1 playing, key 9 preempts, key 1 resumes
    add(16'h0002,  2, 4'd5, 1'b0, 1'b0);
    add(16'h0202,  4, 4'd5, 1'b0, 1'b0);
    add(16'h0202,  1, 4'd1, 1'b1, 1'b1);
    add(16'h0202,  7, 4'd1, 1'b1, 1'b1);
    add(16'h0202,  1, 4'd1, 1'b0, 1'b1);
    add(16'h0202,  1, 4'd1, 1'b0, 1'b1);
    add(16'h0202,  1, 4'd9, 1'b1, 1'b1);
    add(16'h0202,  8, 4'd9, 1'b1, 1'b1);
    add(16'h0002,  6, 4'd9, 1'b1, 1'b1);
    add(16'h0002,  1, 4'd9, 1'b0, 1'b1);
    add(16'h0002,  1, 4'd9, 1'b0, 1'b1);
    add(16'h0002,  1, 4'd1, 1'b1, 1'b1);
    // key 10 pressed so a pend is set one edge before the exit
    add(16'h0402,  7, 4'd1, 1'b1, 1'b1);

    #50;
    chk("rst_hold_50", 4'd0, 1'b0, 1'b0);
    #70;
    chk("rst_hold_120", 4'd0, 1'b0, 1'b0);
    #70;
    chk("rst_hold_190", 4'd0, 1'b0, 1'b0);
    #10;
    RST = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      KEY = vecs[i].key;
      repeat (vecs[i].ticks) tick();
      chk($sformatf("vec%0d", i), vecs[i].b, vecs[i].en, vecs[i].busy);
    end

    #3;
    RST = 1'b1;
    #1;
    chk("rst_async", 4'd0, 1'b0, 1'b0);
    KEY = 16'h0000;
    repeat (2) tick();
    chk("rst_held", 4'd0, 1'b0, 1'b0);
    #3;
    RST = 1'b0;
    repeat (10) tick();
    chk("post_rst_10", 4'd0, 1'b0, 1'b0);
    repeat (10) tick();
    chk("post_rst_20", 4'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
